// File: rtl/calc_alu_mc_if.sv
// Operand/result handshake bundle for calc_alu_mc.
// The master drives operands and out_ready; the slave (the ALU) drives
// in_ready, the result and its flags.
interface calc_alu_mc_if #(
   parameter int WIDTH = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       num1;
   logic [WIDTH-1:0]       num2;
   logic [1:0]             op_sel;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     number_out;
   logic                   flag_carry;
   logic                   flag_zero;

   modport master (
      output in_valid, num1, num2, op_sel, out_ready,
      input  in_ready, out_valid, number_out, flag_carry, flag_zero
   );

   modport slave (
      input  in_valid, num1, num2, op_sel, out_ready,
      output in_ready, out_valid, number_out, flag_carry, flag_zero
   );
endinterface

// File: rtl/calc_alu_mc.sv
// Multi-cycle calculator ALU: add, subtract, absolute difference (one cycle)
// and unsigned shift-add multiply (WIDTH cycles, LSB first).
// Optional macro CALC_ALU_OPCNT_EN adds a 16-bit completed-operation counter
// on port op_count.
module calc_alu_mc #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic          clk,
   input  logic          clear,
   calc_alu_mc_if.slave  bus,
   output logic          busy
`ifdef CALC_ALU_OPCNT_EN
   ,
   output logic [15:0]   op_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_ABS = 2'b11;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   res_q;
   logic                 carry_q;
   logic                 zero_q;

   logic [WIDTH:0]       sum_w;
   logic [WIDTH:0]       diff_w;
   logic [WIDTH-1:0]     abs_w;
   logic                 lt_w;
   logic [2*WIDTH-1:0]   single_res;
   logic                 single_carry;
   logic [2*WIDTH-1:0]   acc_next;

   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.out_valid  = (state_q == S_DONE);
   assign busy           = (state_q == S_MUL);
   assign bus.number_out = res_q;
   assign bus.flag_carry = carry_q;
   assign bus.flag_zero  = zero_q;

   // State register; clear wins over everything, including a pending result.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (clear) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode for the IDLE -> (MUL) -> DONE -> IDLE sequence.
   always_comb begin
      // NOTE: defaulting every combinational output first prevents latches on
      // paths the case statement does not cover.
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.in_valid) state_d = (bus.op_sel == OP_MUL) ? S_MUL : S_DONE;
         S_MUL:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
         S_DONE: if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Single-cycle results and the next multiply partial sum.
   always_comb begin
      sum_w        = {1'b0, bus.num1} + {1'b0, bus.num2};
      diff_w       = {1'b0, bus.num1} - {1'b0, bus.num2};
      lt_w         = (bus.num1 < bus.num2);
      abs_w        = lt_w ? (bus.num2 - bus.num1) : (bus.num1 - bus.num2);
      single_res   = '0;
      single_carry = 1'b0;
      case (bus.op_sel)
         OP_ADD: begin
            single_res   = {{(WIDTH-1){1'b0}}, sum_w};
            single_carry = sum_w[WIDTH];
         end
         OP_SUB: begin
            single_res   = {{(WIDTH-1){1'b0}}, diff_w};
            single_carry = lt_w;
         end
         OP_ABS: begin
            single_res   = {{WIDTH{1'b0}}, abs_w};
            single_carry = lt_w;
         end
         default: begin
            single_res   = '0;
            single_carry = 1'b0;
         end
      endcase
      acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   // Datapath: operand capture, shift-add iteration and result/flag update
   // on DONE entry only.
   always_ff @(posedge clk) begin
      if (clear) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  if (bus.op_sel == OP_MUL) begin
                     cnt_q    <= CNT_W'(WIDTH);
                     acc_q    <= '0;
                     mcand_q  <= {{WIDTH{1'b0}}, bus.num1};
                     mplier_q <= bus.num2;
                  end else begin
                     res_q    <= single_res;
                     carry_q  <= single_carry;
                     zero_q   <= (single_res == '0);
                  end
               end
            end
            S_MUL: begin
               acc_q    <= acc_next;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  res_q   <= acc_next;
                  carry_q <= 1'b0;
                  zero_q  <= (acc_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CALC_ALU_OPCNT_EN
   // Completed-operation counter: steps on each output handshake, wraps.
   always_ff @(posedge clk) begin
      if (clear)                                   op_count <= '0;
      else if ((state_q == S_DONE) && bus.out_ready) op_count <= op_count + 16'd1;
   end
`endif

endmodule

// File: doc/calc_alu_mc.md
Name: calc_alu_mc

Overview:
Parametrised multi-cycle arithmetic unit for the calculator datapath. It supports add, subtract, absolute difference and unsigned multiply. Operands arrive on a valid/ready input handshake. Results leave on a valid/ready output handshake with carry/borrow and zero flags. It sits between operand entry and the display/result register stage.

Parameters:
WIDTH, 16, operand width in bits (>= 2).
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  clock, all state updates on rising edge
clear  in  1  synchronous active-high reset
in_valid  in  1  operands and op presented
in_ready  out  1  block can accept an operation
num1  in  WIDTH  operand A, unsigned
num2  in  WIDTH  operand B, unsigned
op_sel  in  2  00 add, 01 sub, 10 multiply, 11 absolute difference
out_valid  out  1  result valid, held until accepted
out_ready  in  1  downstream accepts result
number_out  out  2*WIDTH  result, zero-extended
flag_carry  out  1  add: carry out of bit WIDTH-1; sub/absdiff: borrow (num1<num2); mul: 0
flag_zero  out  1  number_out == 0
busy  out  1  high in MUL state

Behaviour:
- One clock (clk). Reset (clear) is synchronous and active-high. clear has priority over every other event, including mid-multiply and a pending result.
- After clear: state IDLE, out_valid=0, number_out=0, flag_carry=0, flag_zero=0, busy=0, counter=0, in_ready=1.
- States:
  - IDLE: in_ready=1.
  - MUL: in_ready=0, busy=1.
  - DONE: in_ready=0, out_valid=1.
- Acceptance: in_valid && in_ready at a rising edge (edge E0). Operands and op are captured at E0; inputs are don't-care afterwards.
- Add (00): number_out = num1 + num2, computed in WIDTH+1 bits. IDLE->DONE at E0, so out_valid is high in the cycle after E0 (latency 1).
- Sub (01): number_out = (num1 - num2) mod 2^(WIDTH+1), zero-extended to 2*WIDTH. flag_carry = (num1 < num2). Latency 1.
- Absdiff (11): number_out = |num1 - num2|. flag_carry = (num1 < num2). Latency 1.
- Multiply (10): unsigned shift-add, one multiplier bit per cycle, LSB first.
  - IDLE->MUL at E0; counter loads WIDTH and the accumulator clears.
  - Each MUL edge: add the shifted multiplicand if the current bit is 1, shift, decrement the counter.
  - The edge where the counter reaches 0 moves MUL->DONE with the full 2*WIDTH product. out_valid rises after edge E0+WIDTH (latency WIDTH cycles).
  - flag_carry=0.
- DONE: number_out and the flags are stable while out_valid=1.
  - DONE->IDLE at an edge with out_ready=1; out_valid falls after that edge.
  - No back-to-back overlap: a new operation is accepted no earlier than the cycle after the result is taken (in_ready rises in the cycle after the out handshake).
- out_ready held low: the result is held indefinitely and no new input is accepted.
- number_out/flags keep their last values in IDLE and MUL; they update only on entry to DONE.
- flag_zero is computed from the final result at DONE entry, e.g. 0*x, a-a, 0+0.
- op_sel, num1 and num2 are ignored when in_ready=0.

Optional Feature:
Macro CALC_ALU_OPCNT_EN.
- Defined:
  - Adds output port op_count, out, 16 bits, counting completed operations (out_valid && out_ready edges).
  - Counter wraps 0xFFFF->0x0000.
  - clear resets it to 0.
  - A multiply aborted by clear is not counted.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
WIDTH=16 in all scenarios.
- Add 0xFFFF+0x0001, out_ready=1 -> out_valid the cycle after acceptance, number_out=0x00010000, flag_carry=1, flag_zero=0.
- Sub 5-7 -> number_out=0x0001FFFE, flag_carry=1. Absdiff 5,7 -> number_out=0x00000002, flag_carry=1. Absdiff 9,9 -> 0, flag_zero=1.
- Mul 0xFFFF*0xFFFF -> busy=1 for 16 cycles, out_valid after edge E0+16, number_out=0xFFFE0001. Mul 0x0000*0x1234 -> number_out=0, flag_zero=1.
- Backpressure: add 3+4 with out_ready=0 for 10 cycles while in_valid stays high with new operands -> number_out=7 held, in_ready=0 throughout. Raise out_ready -> one handshake; next operation accepted the following cycle.
- clear asserted at MUL cycle 8 of 0x00FF*0x0101 -> next cycle IDLE, busy=0, out_valid=0, number_out=0, in_ready=1. No stale result appears later.
- With CALC_ALU_OPCNT_EN: 3 completed ops plus 1 aborted multiply -> op_count=3. clear -> op_count=0.
